// File: rtl/async_fifo_rd_stream_if.sv
// Handshake bundle between the async FIFO read port, the read-stream stage and its sink.
// master: the stage's view; slave: the FIFO/sink environment's view.
interface async_fifo_rd_stream_if #(
   parameter int unsigned DSIZE = 8
);
   logic             flush;
   logic             rempty;
   logic [DSIZE-1:0] rdata;
   logic             rinc;
   logic             m_valid;
   logic             m_ready;
   logic [DSIZE-1:0] m_data;

   modport master (
      input  flush,
      input  rempty,
      input  rdata,
      input  m_ready,
      output rinc,
      output m_valid,
      output m_data
   );

   modport slave (
      output flush,
      output rempty,
      output rdata,
      output m_ready,
      input  rinc,
      input  m_valid,
      input  m_data
   );
endinterface

// File: rtl/async_fifo_rd_stream.sv
// Read-domain output stage: pops a show-ahead FIFO into a 2-entry registered valid/ready stream.
// Define ASYNC_FIFO_RD_STREAM_COUNT_EN to add the 16-bit delivered-beat counter m_count.
module async_fifo_rd_stream #(
   parameter int unsigned DSIZE = 8
) (
   input  logic                          rclk,
   input  logic                          rrst,
   async_fifo_rd_stream_if.master        bus
`ifdef ASYNC_FIFO_RD_STREAM_COUNT_EN
   ,
   output logic [15:0]                   m_count
`endif
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } cnt_e;

   cnt_e             cnt_q, cnt_d;
   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic             push;
   logic             pop;

   // rinc looks only at registered state and FIFO/flush inputs, never at m_ready.
   assign push        = !bus.rempty && (cnt_q != StFull) && !bus.flush;
   assign pop         = bus.m_valid && bus.m_ready;
   assign bus.rinc    = push;
   assign bus.m_valid = (cnt_q != StEmpty);
   assign bus.m_data  = head_q;

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      if (bus.flush) begin
         cnt_d = StEmpty;
      end else begin
         unique case (cnt_q)
            StEmpty: begin
               if (push) begin
                  cnt_d  = StOne;
                  head_d = bus.rdata;
               end
            end
            StOne: begin
               if (push && !pop) begin
                  cnt_d  = StFull;
                  tail_d = bus.rdata;
               end else if (pop && !push) begin
                  cnt_d = StEmpty;
               end else if (push && pop) begin
                  head_d = bus.rdata;
               end
            end
            StFull: begin
               if (pop) begin
                  cnt_d  = StOne;
                  head_d = tail_q;
               end
            end
            default: cnt_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt_q  <= StEmpty;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

`ifdef ASYNC_FIFO_RD_STREAM_COUNT_EN
   logic [15:0] count_q, count_d;

   // Counts accepted beats even in a flush cycle; only reset clears it.
   always_comb begin
      count_d = count_q;
      if (pop) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign m_count = count_q;
`endif

endmodule
